// File: rtl/vga_pkg.sv
// Shared definitions for the vga text-mode blocks: geometry defaults,
// control-code constants and the console state encoding.
package vga_pkg;

  localparam int DEFAULT_COLS   = 80;
  localparam int DEFAULT_ROWS   = 25;
  localparam int DEFAULT_ADDR_W = 11;

  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CLEAR_LINE   = 2'd1,
    CLEAR_SCREEN = 2'd2
  } console_state_t;

endpackage

// File: rtl/vga_console.sv
// Byte-stream console front end: tracks a cursor and turns printable/control
// bytes into single-cycle character writes for the vga text buffer.
module vga_console
  import vga_pkg::*;
#(
  parameter int COLS   = DEFAULT_COLS,
  parameter int ROWS   = DEFAULT_ROWS,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        write_char,
  output logic [ADDR_W-1:0] write_char_pos,
  output logic              write_char_strobe,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row
);

  if (COLS * ROWS > 2 ** ADDR_W) begin : g_size_check
    $error("vga_console: COLS*ROWS does not fit in ADDR_W bits");
  end

  localparam logic [6:0]        LAST_COL   = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW   = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LINE_LAST  = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] SCRN_LAST  = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(COLS);

  console_state_t    state_r;
  logic [6:0]        col_r;
  logic [4:0]        row_r;
  logic [ADDR_W-1:0] line_base_r;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic              in_ready_r;
  logic [7:0]        char_r;
  logic [ADDR_W-1:0] pos_r;
  logic              strobe_r;

  logic [4:0]        next_row_s;
  logic [ADDR_W-1:0] next_base_s;
  logic [ADDR_W-1:0] cursor_pos_s;
  logic              accept_s;

  // Next-row target for a line advance; the bottom row wraps to the top.
  always_comb begin
    next_row_s   = 5'd0;
    next_base_s  = '0;
    cursor_pos_s = line_base_r + ADDR_W'(col_r);
    accept_s     = in_valid && in_ready_r;
    if (row_r < LAST_ROW) begin
      next_row_s  = row_r + 5'd1;
      next_base_s = line_base_r + ROW_STRIDE;
    end else begin
      next_row_s  = 5'd0;
      next_base_s = '0;
    end
  end

  // Console state machine, cursor registers and registered write port.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r     <= CLEAR_SCREEN;
      col_r       <= 7'd0;
      row_r       <= 5'd0;
      line_base_r <= '0;
      clr_cnt_r   <= '0;
      in_ready_r  <= 1'b0;
      char_r      <= 8'h00;
      pos_r       <= '0;
      strobe_r    <= 1'b0;
    end else begin
      strobe_r <= 1'b0;
      case (state_r)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (accept_s) begin
            if (in_data >= CHAR_SPACE) begin
              strobe_r <= 1'b1;
              char_r   <= in_data;
              pos_r    <= cursor_pos_s;
              if (col_r < LAST_COL) begin
                col_r <= col_r + 7'd1;
              end else begin
                // Wrap: the char write goes out now, the line clear starts next cycle.
                col_r       <= 7'd0;
                row_r       <= next_row_s;
                line_base_r <= next_base_s;
                clr_cnt_r   <= '0;
                in_ready_r  <= 1'b0;
                state_r     <= CLEAR_LINE;
              end
            end else if (in_data == CHAR_LF) begin
              // LF has no write of its own, so its first clear strobe issues immediately.
              col_r       <= 7'd0;
              row_r       <= next_row_s;
              line_base_r <= next_base_s;
              strobe_r    <= 1'b1;
              char_r      <= CHAR_SPACE;
              pos_r       <= next_base_s;
              clr_cnt_r   <= ADDR_W'(1);
              in_ready_r  <= 1'b0;
              state_r     <= CLEAR_LINE;
            end else if (in_data == CHAR_CR) begin
              col_r <= 7'd0;
            end else if (in_data == CHAR_BS) begin
              if (col_r != 7'd0) begin
                col_r    <= col_r - 7'd1;
                strobe_r <= 1'b1;
                char_r   <= CHAR_SPACE;
                pos_r    <= cursor_pos_s - ADDR_W'(1);
              end else begin
                col_r <= col_r;
              end
            end else if (in_data == CHAR_FF) begin
              clr_cnt_r  <= '0;
              in_ready_r <= 1'b0;
              state_r    <= CLEAR_SCREEN;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CLEAR_LINE: begin
          in_ready_r <= 1'b0;
          strobe_r   <= 1'b1;
          char_r     <= CHAR_SPACE;
          pos_r      <= line_base_r + clr_cnt_r;
          if (clr_cnt_r == LINE_LAST) begin
            clr_cnt_r <= '0;
            state_r   <= IDLE;
          end else begin
            clr_cnt_r <= clr_cnt_r + ADDR_W'(1);
          end
        end
        CLEAR_SCREEN: begin
          in_ready_r <= 1'b0;
          strobe_r   <= 1'b1;
          char_r     <= CHAR_SPACE;
          pos_r      <= clr_cnt_r;
          if (clr_cnt_r == SCRN_LAST) begin
            clr_cnt_r   <= '0;
            col_r       <= 7'd0;
            row_r       <= 5'd0;
            line_base_r <= '0;
            state_r     <= IDLE;
          end else begin
            clr_cnt_r <= clr_cnt_r + ADDR_W'(1);
          end
        end
        default: begin
          clr_cnt_r  <= '0;
          in_ready_r <= 1'b0;
          state_r    <= CLEAR_SCREEN;
        end
      endcase
    end
  end

  assign in_ready          = in_ready_r;
  assign write_char        = char_r;
  assign write_char_pos    = pos_r;
  assign write_char_strobe = strobe_r;
  assign cursor_col        = col_r;
  assign cursor_row        = row_r;

endmodule

// File: tb/tb_vga_console.sv
// Scoreboard bench for vga_console: stimulus queues expected writes, a
// monitor pops and compares every strobe the DUT presents.
module tb_vga_console;
  import vga_pkg::*;

  typedef struct packed {
    logic [7:0]  ch;
    logic [10:0] pos;
  } wr_t;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  write_char;
  logic [10:0] write_char_pos;
  logic        write_char_strobe;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int prev_cyc = -10;
  int last_cyc = -10;
  wr_t exp_q[$];

  vga_console dut (
    .CLK(CLK), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .write_char(write_char), .write_char_pos(write_char_pos),
    .write_char_strobe(write_char_strobe), .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Monitor: every strobe must match the oldest outstanding expected write.
  initial forever begin
    wr_t e;
    @(negedge CLK);
    if (write_char_strobe) begin
      prev_cyc = last_cyc;
      last_cyc = cyc;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got char=%h pos=%0d, required no write", write_char, write_char_pos);
      end else begin
        e = exp_q.pop_front();
        if (write_char == e.ch && write_char_pos == e.pos) pass_cnt++;
        else $display("FAIL write: got char=%h pos=%0d, required char=%h pos=%0d",
                      write_char, write_char_pos, e.ch, e.pos);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  function automatic void push(input logic [7:0] c, input int p);
    wr_t e;
    e.ch  = c;
    e.pos = 11'(p);
    exp_q.push_back(e);
  endfunction

  function automatic void push_line_clear(input int base);
    for (int i = 0; i < 80; i++) push(8'h20, base + i);
  endfunction

  function automatic void push_screen_clear();
    for (int i = 0; i < 2000; i++) push(8'h20, i);
  endfunction

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge CLK);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge CLK);
  endtask

  task automatic wait_ready(input int bound);
    int n = 0;
    @(negedge CLK);
    while (!in_ready && n < bound) begin
      @(negedge CLK);
      n++;
    end
    check("wait_ready", int'(in_ready), 1);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge CLK);
    while (!in_ready && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL send_timeout: got in_ready=0 for byte %h, required 1", b);
    end else begin
      in_data  = b;
      in_valid = 1'b1;
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
    end
  endtask

  initial begin
    int n;
    // Reset state and the initial full-screen clear.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_strobe", int'(write_char_strobe), 0);
    check("rst_ready", int'(in_ready), 0);
    check("rst_char", int'(write_char), 0);
    check("rst_pos", int'(write_char_pos), 0);
    push_screen_clear();
    @(posedge CLK);
    #1 reset = 1'b0;
    drain(5000);
    wait_ready(10);
    check("init_col", int'(cursor_col), 0);
    check("init_row", int'(cursor_row), 0);

    // Back-to-back printables.
    push(8'h41, 0);
    push(8'h42, 1);
    send(8'h41);
    send(8'h42);
    drain(10);
    check("ab_consecutive", last_cyc - prev_cyc, 1);
    check("ab_col", int'(cursor_col), 2);

    // Move to (3,10) and line-feed into row 4.
    send(CHAR_CR);
    check("cr_col0", int'(cursor_col), 0);
    for (int r = 1; r <= 3; r++) begin
      push_line_clear(r * 80);
      send(CHAR_LF);
    end
    for (int i = 0; i < 10; i++) begin
      push(8'h61 + 8'(i), 240 + i);
      send(8'h61 + 8'(i));
    end
    drain(400);
    check("pre_lf_row", int'(cursor_row), 3);
    check("pre_lf_col", int'(cursor_col), 10);
    push_line_clear(320);
    send(CHAR_LF);
    check("lf_col", int'(cursor_col), 0);
    check("lf_row", int'(cursor_row), 4);
    n = 0;
    @(negedge CLK);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge CLK);
    end
    check("lf_ready_low_cycles", n, 80);
    drain(200);

    // Fill the bottom row and wrap to the top.
    for (int r = 5; r <= 24; r++) begin
      push_line_clear(r * 80);
      send(CHAR_LF);
    end
    drain(3000);
    check("bottom_row", int'(cursor_row), 24);
    for (int i = 0; i < 80; i++) push(8'h41 + 8'(i % 26), 1920 + i);
    push_line_clear(0);
    for (int i = 0; i < 80; i++) send(8'h41 + 8'(i % 26));
    drain(400);
    wait_ready(200);
    check("wrap_col", int'(cursor_col), 0);
    check("wrap_row", int'(cursor_row), 0);

    // Backspace, carriage return and ignored codes.
    for (int i = 0; i < 5; i++) begin
      push(8'h78, i);
      send(8'h78);
    end
    push(8'h20, 4);
    send(CHAR_BS);
    check("bs_col", int'(cursor_col), 4);
    drain(10);
    send(CHAR_CR);
    check("cr_col", int'(cursor_col), 0);
    @(negedge CLK);
    check("cr_ready", int'(in_ready), 1);
    send(CHAR_BS);
    check("bs0_col", int'(cursor_col), 0);
    for (int i = 0; i < 7; i++) begin
      push(8'h79, i);
      send(8'h79);
    end
    check("col7", int'(cursor_col), 7);
    send(CHAR_CR);
    check("cr7_col", int'(cursor_col), 0);
    send(8'h01);
    check("ignored_col", int'(cursor_col), 0);
    check("ignored_row", int'(cursor_row), 0);
    drain(10);

    // Reset in the middle of a form-feed clear.
    push_screen_clear();
    send(CHAR_FF);
    n = 0;
    while (exp_q.size() > 1500 && n < 3000) begin
      @(posedge CLK);
      n++;
    end
    #1 reset = 1'b1;
    @(posedge CLK);
    #1 exp_q.delete();
    @(negedge CLK);
    check("abort_strobe", int'(write_char_strobe), 0);
    check("abort_ready", int'(in_ready), 0);
    @(posedge CLK);
    push_screen_clear();
    #1 reset = 1'b0;
    drain(5000);
    wait_ready(10);
    check("restart_col", int'(cursor_col), 0);
    check("restart_row", int'(cursor_row), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
